// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART definitions: FSM state encoding and serial line
//           levels, used by the transmitter and available to the receiver.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame sequencing states; width fixed at 3 bits so both directions of
  // the UART share one encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  // Serial line levels
  localparam logic c_LINE_IDLE  = 1'b1;
  localparam logic c_LINE_START = 1'b0;
  localparam logic c_LINE_STOP  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_bit_timer
// Purpose : Bit-period counter. Counts enabled cycles and pulses o_bit_end on
//           the last cycle of every CLKS_PER_BIT-cycle period.
// Ports   : i_Clock   - clock, rising edge
//           i_Reset   - synchronous active-high reset
//           i_clear   - synchronous clear (restarts the period)
//           i_enable  - count enable
//           o_bit_end - high on the final cycle of a bit period
// Revision: 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int               CNT_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // Combinational so the owning FSM can change state on the same edge that
  // ends the period; with CLKS_PER_BIT=1 this is high every enabled cycle.
  assign o_bit_end = i_enable && (r_count == c_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      // Wrap at period end so consecutive data bits need no external clear.
      r_count <= o_bit_end ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : UART transmitter. 1 start bit, DATA_BITS data bits LSB first,
//           1 stop bit, no parity; each bit held CLKS_PER_BIT clocks.
// Ports   : i_Clock     - clock, rising edge
//           i_Reset     - synchronous active-high reset
//           i_Tx_DV     - one-cycle request strobe (honoured in IDLE only)
//           i_Tx_Data   - payload, captured when the request is accepted
//           o_Tx_Active - high from the start bit through the stop bit
//           o_Tx_Serial - serial line, idles high
//           o_Tx_Done   - one-cycle pulse after the stop bit completes
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_next;
  logic                 r_active;
  logic                 w_active_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_serial;
  logic                 w_serial_next;
  logic                 w_data_bit;
  logic                 w_bit_end;
  logic                 w_timer_en;
  logic                 w_state_change;

  // Bit timing: counts only while a frame bit is on the line and restarts
  // on every state transition.
  assign w_timer_en     = (r_state == ST_START) || (r_state == ST_DATA) ||
                          (r_state == ST_STOP);
  assign w_state_change = (w_state_next != r_state);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_clear   (w_state_change),
    .i_enable  (w_timer_en),
    .o_bit_end (w_bit_end)
  );

  // State register and all registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_data   <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_serial <= c_LINE_IDLE;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_data   <= w_data_next;
      r_active <= w_active_next;
      r_done   <= w_done_next;
      r_serial <= w_serial_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_data_next   = r_data;
    w_active_next = r_active;
    w_done_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_active_next = 1'b0;
        if (i_Tx_DV) begin
          w_data_next   = i_Tx_Data;
          w_active_next = 1'b1;
          w_idx_next    = '0;
          w_state_next  = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_idx_next   = '0;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_idx_next   = '0;
            w_state_next = ST_STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        // Done is registered here, so its single-cycle pulse coincides with
        // the CLEANUP cycle and is gone by the following IDLE cycle.
        if (w_bit_end) begin
          w_done_next   = 1'b1;
          w_active_next = 1'b0;
          w_state_next  = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_active_next = 1'b0;
      end
    endcase
  end

  // Payload bit that will be on the line next cycle (selected by next index)
  always_comb begin
    w_data_bit = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_data_bit = w_data_next[i];
      end
    end
  end

  // Serial level is decoded from the next state and registered, giving a
  // glitch-free line that changes one cycle after acceptance.
  always_comb begin
    w_serial_next = c_LINE_IDLE;
    case (w_state_next)
      ST_START: w_serial_next = c_LINE_START;
      ST_DATA:  w_serial_next = w_data_bit;
      ST_STOP:  w_serial_next = c_LINE_STOP;
      default:  w_serial_next = c_LINE_IDLE;
    endcase
  end

  assign o_Tx_Active = r_active;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = r_done;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx
// Purpose : Self-checking bench for uart_tx. Three instances cover 8-bit and
//           16-bit payloads at one clock per bit and 8-bit at four clocks
//           per bit. Expected line bits are queued when a request is driven
//           and popped as the line is observed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        dv_a, act_a, ser_a, done_a;
  logic [7:0]  data_a;
  logic        dv_b, act_b, ser_b, done_b;
  logic [15:0] data_b;
  logic        dv_c, act_c, ser_c, done_c;
  logic [7:0]  data_c;

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) u_dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Data(data_a),
    .o_Tx_Active(act_a), .o_Tx_Serial(ser_a), .o_Tx_Done(done_a));

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(16)) u_dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Data(data_b),
    .o_Tx_Active(act_b), .o_Tx_Serial(ser_b), .o_Tx_Done(done_b));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_c), .i_Tx_Data(data_c),
    .o_Tx_Active(act_c), .o_Tx_Serial(ser_c), .o_Tx_Done(done_c));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_q[$];
  logic [7:0]  byte_q[$];

  // Queue the expected line levels of one frame: start, data LSB first, stop.
  task automatic push_frame(input logic [31:0] d, input int nbits);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic pop_exp(output logic e);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 1'bx;
  endtask

  // Reset state; a request held during reset must not be queued.
  task automatic test_reset();
    rst = 1'b1; dv_a = 1'b1; data_a = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ser_a, act_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL reset_a: ser/act/done=%b required 100", {ser_a, act_a, done_a});
    end
    n_checks++;
    if ({ser_b, act_b, done_b} !== 3'b100) begin
      n_fail++; $display("FAIL reset_b: ser/act/done=%b required 100", {ser_b, act_b, done_b});
    end
    n_checks++;
    if ({ser_c, act_c, done_c} !== 3'b100) begin
      n_fail++; $display("FAIL reset_c: ser/act/done=%b required 100", {ser_c, act_c, done_c});
    end
    dv_a = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ser_a, act_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL reset_dv_ignored: ser/act/done=%b required 100", {ser_a, act_a, done_a});
    end
  endtask

  // 0x55 at one clock per bit; payload input changes right after acceptance.
  task automatic test_basic_frame();
    logic e;
    dv_a = 1'b1; data_a = 8'h55; push_frame(32'h55, 8);
    @(negedge clk);
    dv_a = 1'b0; data_a = 8'h00;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e || act_a !== 1'b1 || done_a !== 1'b0) begin
        n_fail++; $display("FAIL basic_bit%0d: ser=%b act=%b done=%b required ser=%b act=1 done=0", i, ser_a, act_a, done_a, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1 || act_a !== 1'b0 || ser_a !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: done=%b act=%b ser=%b required 1 0 1", done_a, act_a, ser_a);
    end
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_single: done=%b required 0", done_a);
    end
  endtask

  // 0xDEAD on a 16-bit instance: bit sequence, active width, one done pulse.
  task automatic test_wide_frame();
    logic e;
    int   act_cnt, done_cnt;
    act_cnt = 0; done_cnt = 0;
    dv_b = 1'b1; data_b = 16'hDEAD; push_frame(32'hDEAD, 16);
    @(negedge clk);
    dv_b = 1'b0; data_b = 16'h0000;
    for (int i = 0; i < 24; i++) begin
      if (act_b === 1'b1) act_cnt++;
      if (done_b === 1'b1) done_cnt++;
      if (i < 18) begin
        pop_exp(e);
        n_checks++;
        if (ser_b !== e) begin
          n_fail++; $display("FAIL wide_bit%0d: ser=%b required %b", i, ser_b, e);
        end
      end
      if (i == 18) begin
        n_checks++;
        if (done_b !== 1'b1) begin
          n_fail++; $display("FAIL wide_done_time: done=%b required 1", done_b);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (act_cnt != 18) begin
      n_fail++; $display("FAIL wide_active_len: active cycles=%0d required 18", act_cnt);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL wide_done_count: pulses=%0d required 1", done_cnt);
    end
  endtask

  // 0xA3 at four clocks per bit; every cycle checked, centres decoded.
  task automatic test_oversample();
    logic       cur;
    logic [7:0] rec;
    logic [7:0] want;
    cur = 1'b1; rec = 8'h00;
    dv_c = 1'b1; data_c = 8'hA3; push_frame(32'hA3, 8); byte_q.push_back(8'hA3);
    @(negedge clk);
    dv_c = 1'b0; data_c = 8'hFF;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc % 4 == 0) pop_exp(cur);
      n_checks++;
      if (ser_c !== cur || act_c !== 1'b1 || done_c !== 1'b0) begin
        n_fail++; $display("FAIL over_cyc%0d: ser=%b act=%b done=%b required ser=%b act=1 done=0", cyc, ser_c, act_c, done_c, cur);
      end
      if (cyc % 4 == 2 && cyc / 4 >= 1 && cyc / 4 <= 8) rec[cyc / 4 - 1] = ser_c;
      @(negedge clk);
    end
    n_checks++;
    if (done_c !== 1'b1 || act_c !== 1'b0) begin
      n_fail++; $display("FAIL over_done: done=%b act=%b required 1 0", done_c, act_c);
    end
    want = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
    n_checks++;
    if (rec !== want) begin
      n_fail++; $display("FAIL over_recover: got %h required %h", rec, want);
    end
    repeat (2) @(negedge clk);
  endtask

  // Request during DATA of a 0xF0 frame is dropped, not queued.
  task automatic test_ignore_dv();
    logic e;
    int   bad;
    bad = 0;
    dv_a = 1'b1; data_a = 8'hF0; push_frame(32'hF0, 8);
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e) begin
        n_fail++; $display("FAIL ignore_bit%0d: ser=%b required %b", i, ser_a, e);
      end
      if (i == 3) begin dv_a = 1'b1; data_a = 8'h12; end
      if (i == 4) dv_a = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++; $display("FAIL ignore_done: done=%b required 1", done_a);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || act_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ignore_no_second_frame: %0d busy cycles required 0", bad);
    end
  endtask

  // Reset during data bit 3 aborts; then 0x3C goes out cleanly.
  task automatic test_reset_midframe();
    logic e;
    int   bad;
    bad = 0;
    dv_a = 1'b1; data_a = 8'hC3; push_frame(32'hC3, 8);
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e) begin
        n_fail++; $display("FAIL abort_bit%0d: ser=%b required %b", i, ser_a, e);
      end
      if (i == 4) begin rst = 1'b1; dv_a = 1'b1; data_a = 8'h99; end
      else @(negedge clk);
    end
    @(negedge clk);
    exp_q.delete();
    n_checks++;
    if ({ser_a, act_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL abort_state: ser/act/done=%b required 100", {ser_a, act_a, done_a});
    end
    rst = 1'b0; dv_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || act_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d busy cycles required 0", bad);
    end
    dv_a = 1'b1; data_a = 8'h3C; push_frame(32'h3C, 8);
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e) begin
        n_fail++; $display("FAIL after_abort_bit%0d: ser=%b required %b", i, ser_a, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++; $display("FAIL after_abort_done: done=%b required 1", done_a);
    end
    @(negedge clk);
  endtask

  // Back-to-back: request raised in CLEANUP (ignored) and held into the
  // first IDLE cycle; the next start bit follows that single IDLE cycle.
  task automatic test_back_to_back();
    logic e;
    dv_a = 1'b1; data_a = 8'h81; push_frame(32'h81, 8);
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e) begin
        n_fail++; $display("FAIL b2b_first_bit%0d: ser=%b required %b", i, ser_a, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1 || ser_a !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cleanup: done=%b ser=%b required 1 1", done_a, ser_a);
    end
    dv_a = 1'b1; data_a = 8'h7E; push_frame(32'h7E, 8);
    @(negedge clk);
    n_checks++;
    if ({ser_a, act_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_idle_gap: ser/act/done=%b required 100", {ser_a, act_a, done_a});
    end
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      n_checks++;
      if (ser_a !== e || act_a !== 1'b1) begin
        n_fail++; $display("FAIL b2b_second_bit%0d: ser=%b act=%b required ser=%b act=1", i, ser_a, act_a, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_done: done=%b required 1", done_a);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dv_a = 1'b0; data_a = '0;
    dv_b = 1'b0; data_b = '0;
    dv_c = 1'b0; data_c = '0;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_wide_frame();
    test_oversample();
    test_ignore_dv();
    test_reset_midframe();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL queue_drained: %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_tx
`default_nettype wire
